affine_window_accum: RTL



---
 rtl/affine_window_accum.sv | 89 ++++++++
 1 files changed

// File: rtl/affine_window_accum.sv
// Windowed accumulator behind the 8-bit affine datapath: sums N accepted samples
// and holds each window sum on a valid/ready output until it is consumed.
module affine_window_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int N         = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic                 CLR,
  output logic [ACC_WIDTH-1:0] O,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [7:0]           cnt
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum_next;
  logic [7:0]           cnt_inc;
  logic                 sample_take;
  logic                 window_done;

  // The first sample of a window overwrites acc, so no separate clear cycle is needed.
  assign sum_next = (cnt == 8'd0) ? ACC_WIDTH'(I) : acc + ACC_WIDTH'(I);
  assign cnt_inc  = cnt + 8'd1;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= ACCUM;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and infers a latch.
    state_next  = state;
    I_ready     = 1'b0;
    O_valid     = 1'b0;
    sample_take = 1'b0;
    window_done = 1'b0;
    case (state)
      ACCUM: begin
        // Held low during reset so upstream never sees a ready it cannot use.
        I_ready     = ASYNCRESETN;
        sample_take = I_valid && !CLR;
        window_done = sample_take && (cnt_inc == 8'(N));
        if (window_done) state_next = DONE;
      end
      DONE: begin
        O_valid = 1'b1;
        if (O_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      acc <= '0;
      cnt <= '0;
      O   <= '0;
    end else if (state == ACCUM) begin
      // CLR wins over a coincident sample; DONE ignores CLR so a finished window survives.
      if (CLR) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_take) begin
        acc <= sum_next;
        if (window_done) begin
          O   <= sum_next;
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule
